// File: rtl/multicycle_ctrl_p_if.sv
// multicycle_ctrl_p_if: opcode and data-memory handshake into the
// controller, datapath control and status out of it.
// Ports (slave = controller side, master = datapath side):
//   opcode, dmem_ready            datapath -> controller
//   pc_write .. reg_read_sel      controller -> datapath enables/selects
//   halted, trap, state_dbg       controller status
interface multicycle_ctrl_p_if #(
    parameter int OPW  = 6,
    parameter int ALUW = 4
);
    logic [OPW-1:0]  opcode;
    logic            dmem_ready;
    logic            pc_write;
    logic            pc_write_cond;
    logic            ir_write;
    logic            reg_write;
    logic            dmem_write;
    logic            dmem_read;
    logic [1:0]      pc_source;
    logic [1:0]      mem_to_reg;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [ALUW-1:0] alu_sel;
    logic            reg_read_sel;
    logic            halted;
    logic            trap;
    logic [4:0]      state_dbg;

    modport slave (
        input  opcode, dmem_ready,
        output pc_write, pc_write_cond, ir_write, reg_write,
               dmem_write, dmem_read, pc_source, mem_to_reg,
               alu_src_a, alu_src_b, alu_sel, reg_read_sel,
               halted, trap, state_dbg
    );

    modport master (
        output opcode, dmem_ready,
        input  pc_write, pc_write_cond, ir_write, reg_write,
               dmem_write, dmem_read, pc_source, mem_to_reg,
               alu_src_a, alu_src_b, alu_sel, reg_read_sel,
               halted, trap, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_p.sv
// multicycle_ctrl_p: Moore multicycle controller with memory wait/timeout,
// HALT and illegal-opcode trap. Ports: clk, reset_n, bus (slave modport).
module multicycle_ctrl_p #(
    parameter int OPW         = 6,
    parameter int ALUW        = 4,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    multicycle_ctrl_p_if.slave bus
);
    localparam int SW = OPW - 2;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_RST    = 5'd0,  S_IF     = 5'd1,  S_ID     = 5'd2,
        S_EX_R   = 5'd3,  S_EX_IS  = 5'd4,  S_EX_IZ  = 5'd5,
        S_WB_ALU = 5'd6,  S_JMP    = 5'd7,  S_R1RD   = 5'd8,
        S_BR     = 5'd9,  S_WB_LI  = 5'd10, S_WB_LUI = 5'd11,
        S_MEM_RD = 5'd12, S_MEM_WR = 5'd13, S_WB_MEM = 5'd14,
        S_HALT   = 5'd15, S_TRAP   = 5'd16
    } state_t;

    typedef struct packed {
        logic            pc_write;
        logic            pc_write_cond;
        logic            ir_write;
        logic            reg_write;
        logic            dmem_write;
        logic            dmem_read;
        logic [1:0]      pc_source;
        logic [1:0]      mem_to_reg;
        logic            alu_src_a;
        logic [1:0]      alu_src_b;
        logic [ALUW-1:0] alu_sel;
        logic            reg_read_sel;
    } ctl_t;

    state_t       st, nxt;
    logic [7:0]   wcnt, wcnt_nxt;
    ctl_t         ctl;
    logic         halted_q, trap_q;
    logic [1:0]   cls;
    logic [SW-1:0] sub;

    assign cls = bus.opcode[OPW-1:OPW-2];
    assign sub = bus.opcode[SW-1:0];

    function automatic logic is_sub(input logic [SW-1:0] s, input int v);
        return s == SW'(v);
    endfunction

    function automatic logic [ALUW-1:0] zx(input logic [3:0] v);
        logic [31:0] w;
        w = {28'd0, v};
        return w[ALUW-1:0];
    endfunction

    // Control word for the state being entered; lo is the sub-op's low
    // nibble, which feeds alu_sel in the EX states.
    function automatic ctl_t decode(input state_t s, input logic [3:0] lo);
        ctl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
            S_IF: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_sel   = zx(4'd2);
                c.alu_src_b = 2'b01;
            end
            S_ID: begin
                c.alu_sel   = zx(4'd2);
                c.alu_src_b = 2'b10;
            end
            S_EX_R: begin
                c.alu_sel   = zx(lo);
                c.alu_src_a = 1'b1;
            end
            S_EX_IS: begin
                c.alu_sel   = zx(lo);
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_EX_IZ: begin
                c.alu_sel   = zx(lo);
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b11;
            end
            S_WB_ALU: c.reg_write = 1'b1;
            S_JMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_R1RD: begin
                c.reg_read_sel = 1'b1;
                c.alu_sel      = zx(4'd2);
                c.alu_src_b    = 2'b10;
            end
            S_BR: begin
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.alu_sel       = zx(4'd3);
                c.alu_src_a     = 1'b1;
                c.reg_read_sel  = 1'b1;
            end
            S_WB_LI: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
            end
            S_WB_LUI: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b11;
            end
            S_MEM_RD: c.dmem_read = 1'b1;
            S_MEM_WR: c.dmem_write = 1'b1;
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt      = S_IF;
        wcnt_nxt = 8'd0;
        case (st)
            S_IF: nxt = S_ID;
            S_ID: begin
                case (cls)
                    2'b01: nxt = S_EX_R;
                    2'b00: begin
                        if (sub == '0)
                            nxt = S_IF;
                        else if (&sub)
                            nxt = S_HALT;
                        else
                            nxt = S_JMP;
                    end
                    2'b10: nxt = S_R1RD;
                    default: begin
                        if (is_sub(sub, 2) || is_sub(sub, 3) || is_sub(sub, 7))
                            nxt = S_EX_IS;
                        else if (is_sub(sub, 4) || is_sub(sub, 5) || is_sub(sub, 6))
                            nxt = S_EX_IZ;
                        else if (is_sub(sub, 11))
                            nxt = S_MEM_RD;
                        else if (is_sub(sub, 9) || is_sub(sub, 10) || is_sub(sub, 12))
                            nxt = S_R1RD;
                        else
                            nxt = S_TRAP;
                    end
                endcase
            end
            S_EX_R, S_EX_IS, S_EX_IZ: nxt = S_WB_ALU;
            S_R1RD: begin
                if (cls == 2'b10)
                    nxt = S_BR;
                else if (cls == 2'b11 && is_sub(sub, 9))
                    nxt = S_WB_LI;
                else if (cls == 2'b11 && is_sub(sub, 10))
                    nxt = S_WB_LUI;
                else if (cls == 2'b11 && is_sub(sub, 12))
                    nxt = S_MEM_WR;
                else
                    nxt = S_IF;
            end
            S_MEM_RD, S_MEM_WR: begin
                // ready is checked before the timeout so it wins a tie
                if (!MEM_WAIT_EN || bus.dmem_ready)
                    nxt = (st == S_MEM_RD) ? S_WB_MEM : S_IF;
                else if (wcnt == WAIT_LAST)
                    nxt = S_TRAP;
                else begin
                    nxt      = st;
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            S_HALT: nxt = S_HALT;
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= S_RST;
            wcnt     <= 8'd0;
            ctl      <= decode(S_RST, 4'd0);
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            st       <= nxt;
            wcnt     <= wcnt_nxt;
            ctl      <= decode(nxt, bus.opcode[3:0]);
            halted_q <= halted_q | (nxt == S_HALT);
            trap_q   <= trap_q | (nxt == S_TRAP);
        end
    end

    assign bus.pc_write      = ctl.pc_write;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.ir_write      = ctl.ir_write;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.dmem_write    = ctl.dmem_write;
    assign bus.dmem_read     = ctl.dmem_read;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.alu_sel       = ctl.alu_sel;
    assign bus.reg_read_sel  = ctl.reg_read_sel;
    assign bus.halted        = halted_q;
    assign bus.trap          = trap_q;
    assign bus.state_dbg     = st;
endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// tb_multicycle_ctrl_p: table vectors, hand sequences and random
// instructions checked against an instruction-level expectation model.
module tb_multicycle_ctrl_p;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_p_if #(.OPW(6), .ALUW(4)) bus();

    multicycle_ctrl_p #(
        .OPW(6), .ALUW(4), .MEM_WAIT_EN(1'b1), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct packed {
        logic pcw, pcwc, irw, rw, dw, dr;
        logic [1:0] pcs, m2r;
        logic sa;
        logic [1:0] sb;
        logic [3:0] sel;
        logic rrs, hlt, trp;
    } exp_t;

    typedef struct {
        exp_t e;
        logic rdy;
        logic [5:0] op;
    } step_t;

    typedef struct {
        logic [5:0] op;
        int stalls;
        int cpi;
        int fin;
    } vec_t;

    int tests = 0;
    int fails = 0;
    step_t seq[$];

    exp_t W_RST, W_IF, W_ID, W_WBALU, W_JMP, W_R1RD, W_BR;
    exp_t W_MRD, W_MWR, W_WBMEM, W_WBLI, W_WBLUI, W_HLT, W_TRP;

    function automatic exp_t mk(
        input logic pcw, pcwc, irw, rw, dw, dr,
        input logic [1:0] pcs, m2r,
        input logic sa,
        input logic [1:0] sb,
        input logic [3:0] sel,
        input logic rrs
    );
        exp_t x;
        x.pcw = pcw; x.pcwc = pcwc; x.irw = irw; x.rw = rw;
        x.dw = dw; x.dr = dr; x.pcs = pcs; x.m2r = m2r;
        x.sa = sa; x.sb = sb; x.sel = sel; x.rrs = rrs;
        x.hlt = 1'b0; x.trp = 1'b0;
        return x;
    endfunction

    function automatic exp_t sample();
        exp_t x;
        x.pcw = bus.pc_write; x.pcwc = bus.pc_write_cond;
        x.irw = bus.ir_write; x.rw = bus.reg_write;
        x.dw = bus.dmem_write; x.dr = bus.dmem_read;
        x.pcs = bus.pc_source; x.m2r = bus.mem_to_reg;
        x.sa = bus.alu_src_a; x.sb = bus.alu_src_b;
        x.sel = bus.alu_sel; x.rrs = bus.reg_read_sel;
        x.hlt = bus.halted; x.trp = bus.trap;
        return x;
    endfunction

    task automatic check(input string nm, input exp_t got, input exp_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic init_words();
        W_RST   = mk(1,0,0,0,0,0, 2'd3,2'd0, 0,2'd0, 4'd0, 0);
        W_IF    = mk(1,0,1,0,0,0, 2'd0,2'd0, 0,2'd1, 4'd2, 0);
        W_ID    = mk(0,0,0,0,0,0, 2'd0,2'd0, 0,2'd2, 4'd2, 0);
        W_WBALU = mk(0,0,0,1,0,0, 2'd0,2'd0, 0,2'd0, 4'd0, 0);
        W_JMP   = mk(1,0,0,0,0,0, 2'd2,2'd0, 0,2'd0, 4'd0, 0);
        W_R1RD  = mk(0,0,0,0,0,0, 2'd0,2'd0, 0,2'd2, 4'd2, 1);
        W_BR    = mk(0,1,0,0,0,0, 2'd1,2'd0, 1,2'd0, 4'd3, 1);
        W_MRD   = mk(0,0,0,0,0,1, 2'd0,2'd0, 0,2'd0, 4'd0, 0);
        W_MWR   = mk(0,0,0,0,1,0, 2'd0,2'd0, 0,2'd0, 4'd0, 0);
        W_WBMEM = mk(0,0,0,1,0,0, 2'd0,2'd1, 0,2'd0, 4'd0, 0);
        W_WBLI  = mk(0,0,0,1,0,0, 2'd0,2'd2, 0,2'd0, 4'd0, 0);
        W_WBLUI = mk(0,0,0,1,0,0, 2'd0,2'd3, 0,2'd0, 4'd0, 0);
        W_HLT   = '0;
        W_HLT.hlt = 1'b1;
        W_TRP   = '0;
        W_TRP.trp = 1'b1;
    endtask

    task automatic push(input exp_t e, input logic rdy, input logic [5:0] op);
        step_t s;
        s.e = e;
        s.rdy = rdy;
        s.op = op;
        seq.push_back(s);
    endtask

    task automatic push_any(input exp_t e, input logic [5:0] op);
        push(e, 1'($urandom_range(0, 1)), op);
    endtask

    // Absorbing end: the status word persists while opcode/ready wander.
    task automatic push_absorb(input exp_t e);
        repeat (21) push(e, 1'($urandom_range(0, 1)), 6'($urandom));
    endtask

    task automatic mem_phase(input exp_t w, input int stalls,
                             input logic [5:0] op, output bit timed_out);
        if (stalls >= TO) begin
            repeat (TO) push(w, 1'b0, op);
            push_absorb(W_TRP);
            timed_out = 1'b1;
        end else begin
            repeat (stalls) push(w, 1'b0, op);
            push(w, 1'b1, op);
            timed_out = 1'b0;
        end
    endtask

    // Expected per-cycle control words for one instruction from IF on.
    // fin: 0 = returns to IF, 1 = halts, 2 = traps.
    task automatic build(input logic [5:0] op, input int stalls, output int fin);
        logic [1:0] c;
        int s;
        bit tout;
        exp_t ex;
        c = op[5:4];
        s = int'(op[3:0]);
        seq.delete();
        fin = 0;
        push_any(W_IF, op);
        push_any(W_ID, op);
        if (c == 2'b01) begin
            ex = mk(0,0,0,0,0,0, 2'd0,2'd0, 1,2'd0, op[3:0], 0);
            push_any(ex, op);
            push_any(W_WBALU, op);
        end else if (c == 2'b00) begin
            if (s == 15) begin
                push_absorb(W_HLT);
                fin = 1;
            end else if (s != 0) begin
                push_any(W_JMP, op);
            end
        end else if (c == 2'b10) begin
            push_any(W_R1RD, op);
            push_any(W_BR, op);
        end else begin
            if (s == 2 || s == 3 || s == 7 || s == 4 || s == 5 || s == 6) begin
                ex = mk(0,0,0,0,0,0, 2'd0,2'd0, 1,
                        (s >= 4 && s <= 6) ? 2'd3 : 2'd2, op[3:0], 0);
                push_any(ex, op);
                push_any(W_WBALU, op);
            end else if (s == 11) begin
                mem_phase(W_MRD, stalls, op, tout);
                if (tout) fin = 2;
                else push_any(W_WBMEM, op);
            end else if (s == 9) begin
                push_any(W_R1RD, op);
                push_any(W_WBLI, op);
            end else if (s == 10) begin
                push_any(W_R1RD, op);
                push_any(W_WBLUI, op);
            end else if (s == 12) begin
                push_any(W_R1RD, op);
                mem_phase(W_MWR, stalls, op, tout);
                if (tout) fin = 2;
            end else begin
                push_absorb(W_TRP);
                fin = 2;
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", sample(), W_RST);
        bus.opcode = 6'($urandom);
        bus.dmem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check("rst_hold", sample(), W_RST);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // fin returns 3 when the instruction was aborted by reset.
    task automatic run(input logic [5:0] op, input int stalls, input int abort_at,
                       output int fin, output int cpi);
        int nlow;
        build(op, stalls, fin);
        nlow = 0;
        cpi = -1;
        for (int i = 0; i < seq.size(); i++) begin
            bus.opcode = seq[i].op;
            bus.dmem_ready = seq[i].rdy;
            check($sformatf("op%b_stall%0d_cyc%0d", op, stalls, i), sample(), seq[i].e);
            if (i > 0 && !bus.ir_write) nlow++;
            if (i == abort_at) begin
                apply_reset();
                fin = 3;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (fin == 0) cpi = bus.ir_write ? nlow + 1 : -1;
    endtask

    vec_t vt[$];

    initial begin
        int fin, cpi, ab;
        logic [5:0] op;
        int st;

        init_words();
        vt = '{
            '{6'b000000, 0, 2, 0}, '{6'b000101, 0, 3, 0},
            '{6'b010011, 0, 4, 0}, '{6'b011010, 0, 4, 0},
            '{6'b110010, 0, 4, 0}, '{6'b110111, 0, 4, 0},
            '{6'b110100, 0, 4, 0}, '{6'b110110, 0, 4, 0},
            '{6'b100001, 0, 4, 0}, '{6'b111001, 0, 4, 0},
            '{6'b111010, 0, 4, 0}, '{6'b111100, 0, 4, 0},
            '{6'b111100, 2, 6, 0}, '{6'b111011, 0, 4, 0},
            '{6'b111011, 3, 7, 0}, '{6'b111100, 3, 7, 0},
            '{6'b001111, 0, 0, 1}, '{6'b111110, 0, 0, 2},
            '{6'b110000, 0, 0, 2}, '{6'b111000, 0, 0, 2},
            '{6'b111100, 4, 0, 2}, '{6'b111011, 5, 0, 2}
        };

        bus.opcode = 6'd0;
        bus.dmem_ready = 1'b0;
        apply_reset();

        // reset in EX_R, then in the middle of an LWI wait and an SWI wait
        run(6'b010011, 0, 2, fin, cpi);
        run(6'b111011, 3, 3, fin, cpi);
        run(6'b111100, 3, 4, fin, cpi);

        foreach (vt[k]) begin
            run(vt[k].op, vt[k].stalls, -1, fin, cpi);
            if (vt[k].fin == 0) begin
                check_int($sformatf("cpi_op%b_stall%0d", vt[k].op, vt[k].stalls),
                          cpi, vt[k].cpi);
            end else begin
                check_int($sformatf("flags_op%b", vt[k].op),
                          int'({bus.halted, bus.trap}),
                          (vt[k].fin == 1) ? 2 : 1);
                apply_reset();
            end
        end

        for (int n = 0; n < 200; n++) begin
            op = 6'($urandom);
            st = $urandom_range(0, 5);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : -1;
            run(op, st, ab, fin, cpi);
            if (fin == 1 || fin == 2) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
